// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port 1-cycle-latency RAM.
// Optional locked read-modify-write support is built when ONCHIP_ARB_LOCK_EN is defined.
module onchip_mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int BE_W         = DATA_W / 8,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic       req0, req1;
  logic       allow0, allow1;
  logic       grant0, grant1;
  logic       last;
  logic [1:0] rd_owner;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // last == 1 means m1 was served most recently, so m0 wins a tie
  assign grant0 = req0 & allow0 & (~(req1 & allow1) | last);
  assign grant1 = req1 & allow1 & ~grant0;

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_chipselect = grant0 | grant1;
    mem_write      = grant0 & m0_write;
    if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last     <= 1'b1;
      rd_owner <= 2'b00;
    end else begin
      if (grant0)
        last <= 1'b0;
      else if (grant1)
        last <= 1'b1;
      // a request with both read and write set is treated as a write only
      rd_owner <= {grant1 & m1_read & ~m1_write, grant0 & m0_read & ~m0_write};
    end
  end

  assign m0_readdatavalid = rd_owner[0];
  assign m1_readdatavalid = rd_owner[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

`ifdef ONCHIP_ARB_LOCK_EN
  // state | meaning
  // IDLE  | no lock held, plain round robin
  // OWN0  | m0 holds the RAM, m1 is stalled
  // OWN1  | m1 holds the RAM, m0 is stalled
  localparam int                CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TMO   = CNT_W'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} lock_state_t;

  lock_state_t      state, state_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;

  assign allow0 = (state != OWN1);
  assign allow1 = (state != OWN0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = '0;
    unique case (state)
      IDLE: begin
        if (grant0 && m0_lock)
          state_nxt = OWN0;
        else if (grant1 && m1_lock)
          state_nxt = OWN1;
      end
      OWN0: begin
        if (req0)
          idle_cnt_nxt = '0;
        else if (idle_cnt != TMO)
          idle_cnt_nxt = idle_cnt + 1'b1;
        else
          idle_cnt_nxt = idle_cnt;
        // release on the same edge the counter reaches the limit
        if ((grant0 && !m0_lock) || idle_cnt_nxt == TMO)
          state_nxt = IDLE;
      end
      OWN1: begin
        if (req1)
          idle_cnt_nxt = '0;
        else if (idle_cnt != TMO)
          idle_cnt_nxt = idle_cnt + 1'b1;
        else
          idle_cnt_nxt = idle_cnt;
        if ((grant1 && !m1_lock) || idle_cnt_nxt == TMO)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  logic unused_lock;

  assign allow0      = 1'b1;
  assign allow1      = 1'b1;
  assign unused_lock = m0_lock ^ m1_lock ^ (LOCK_TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter: directed corner cases, a vector table,
// and randomized traffic against a transaction-level reference model.
module tb_onchip_mem_arbiter;
  localparam int ADDR_W = 10, DATA_W = 32, BE_W = 4, LOCK_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic [BE_W-1:0]   m0_byteenable = '0, m1_byteenable = '0;
  logic              m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
  logic              m0_lock = 0, m1_lock = 0;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata = '0;

  int checks = 0;
  int errors = 0;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_lock(m0_lock), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_lock(m1_lock), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int i);
    return 32'hA500_0000 ^ (i * 32'h0001_0003);
  endfunction

  // RAM slave: 1-cycle read latency, byte-lane writes; preloads itself on the first edge
  logic [31:0] ram [0:1023];
  logic ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BE_W; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive0(input bit rd, input bit wr, input int addr, input int be, input logic [31:0] d, input bit lk);
    m0_read = rd; m0_write = wr; m0_address = ADDR_W'(addr); m0_byteenable = BE_W'(be);
    m0_writedata = d; m0_lock = lk;
  endtask

  task automatic drive1(input bit rd, input bit wr, input int addr, input int be, input logic [31:0] d, input bit lk);
    m1_read = rd; m1_write = wr; m1_address = ADDR_W'(addr); m1_byteenable = BE_W'(be);
    m1_writedata = d; m1_lock = lk;
  endtask

  task automatic idle_all();
    drive0(0, 0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_all();
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_wait0", m0_waitrequest, 0);
    chk("rst_wait1", m1_waitrequest, 0);
    chk("rst_rdv0", m0_readdatavalid, 0);
    chk("rst_rdv1", m1_readdatavalid, 0);
    chk("rst_cs", mem_chipselect, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  typedef struct packed {
    bit rd0, wr0, rd1, wr1;
    bit w0, w1, cs, wr, rdv0, rdv1;
    int win;  // 0 none, 1 m0, 2 m1
  } vec_t;

  vec_t vecs [8];

  // reference model state for the random phase
  logic [31:0] ref_mem [0:1023];
  int          mlast;
  int          pend_who;
  logic [31:0] pend_data;

  initial begin
    // rows are applied back to back from reset; expected values follow the arbitration rules by hand
    vecs[0] = '{0,0,0,0, 0,0,0,0,0,0, 0};
    vecs[1] = '{1,0,1,0, 0,1,1,0,0,0, 1};
    vecs[2] = '{1,0,1,0, 1,0,1,0,1,0, 2};
    vecs[3] = '{0,0,0,1, 0,0,1,1,0,1, 2};
    vecs[4] = '{0,1,1,0, 0,1,1,1,0,0, 1};
    vecs[5] = '{1,1,0,0, 0,0,1,1,0,0, 1};
    vecs[6] = '{1,0,0,1, 1,0,1,1,0,0, 2};
    vecs[7] = '{0,0,0,0, 0,0,0,0,0,0, 0};

    // uncontended write then read-back
    apply_reset();
    drive0(0, 1, 'h005, 'hF, 32'hDEADBEEF, 0);
    @(negedge clk);
    chk("wr_wait0", m0_waitrequest, 0);
    chk("wr_cs", mem_chipselect, 1);
    chk("wr_memwrite", mem_write, 1);
    next_cycle();
    drive0(1, 0, 'h005, 'hF, 0, 0);
    @(negedge clk);
    chk("rd_wait0", m0_waitrequest, 0);
    chk("rd_rdv0_early", m0_readdatavalid, 0);
    next_cycle();
    idle_all();
    @(negedge clk);
    chk("rd_rdv0", m0_readdatavalid, 1);
    chk("rd_data0", m0_readdata, 32'hDEADBEEF);
    chk("rd_rdv1", m1_readdatavalid, 0);
    next_cycle();

    // both masters reading continuously: grants alternate starting with m0
    apply_reset();
    drive0(1, 0, 'h020, 'hF, 0, 0);
    drive1(1, 0, 'h021, 'hF, 0, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("alt_wait0", m0_waitrequest, (k % 2 == 1));
      chk("alt_wait1", m1_waitrequest, (k % 2 == 0));
      if (k > 0) begin
        chk("alt_rdv0", m0_readdatavalid, ((k - 1) % 2 == 0));
        chk("alt_rdv1", m1_readdatavalid, ((k - 1) % 2 == 1));
        if ((k - 1) % 2 == 0) chk("alt_data0", m0_readdata, init_val('h020));
        else                  chk("alt_data1", m1_readdata, init_val('h021));
      end
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    chk("alt_rdv1_last", m1_readdatavalid, 1);
    chk("alt_data1_last", m1_readdata, init_val('h021));
    next_cycle();

    // partial byte-enable write at the top address
    apply_reset();
    drive1(0, 1, 'h3FF, 'hF, 32'hFFFFFFFF, 0);
    @(negedge clk);
    chk("be_wait1", m1_waitrequest, 0);
    next_cycle();
    drive1(0, 1, 'h3FF, 'h3, 32'h12345678, 0);
    @(negedge clk);
    chk("be_be", mem_byteenable, 'h3);
    next_cycle();
    drive1(0, 0, 0, 0, 0, 0);
    drive0(1, 0, 'h3FF, 'hF, 0, 0);
    @(negedge clk);
    chk("be_rd_wait0", m0_waitrequest, 0);
    next_cycle();
    idle_all();
    @(negedge clk);
    chk("be_rdv0", m0_readdatavalid, 1);
    chk("be_data", m0_readdata, 32'hFFFF5678);
    next_cycle();

`ifdef ONCHIP_ARB_LOCK_EN
    // locked read-modify-write holds m1 off until the unlocked write
    apply_reset();
    drive0(1, 0, 'h010, 'hF, 0, 1);
    drive1(1, 0, 'h040, 'hF, 0, 0);
    @(negedge clk);
    chk("lk_c0_wait0", m0_waitrequest, 0);
    chk("lk_c0_wait1", m1_waitrequest, 1);
    next_cycle();
    drive0(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lk_c1_wait1", m1_waitrequest, 1);
    next_cycle();
    drive0(0, 1, 'h010, 'hF, 32'h0BADF00D, 0);
    @(negedge clk);
    chk("lk_c2_wait0", m0_waitrequest, 0);
    chk("lk_c2_wait1", m1_waitrequest, 1);
    next_cycle();
    drive0(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lk_c3_wait1", m1_waitrequest, 0);
    next_cycle();
    idle_all();

    // idle timeout releases the lock
    apply_reset();
    drive0(1, 0, 'h010, 'hF, 0, 1);
    drive1(1, 0, 'h040, 'hF, 0, 0);
    @(negedge clk);
    chk("to_c0_wait1", m1_waitrequest, 1);
    next_cycle();
    drive0(0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= LOCK_TIMEOUT; c++) begin
      @(negedge clk);
      chk("to_held_wait1", m1_waitrequest, 1);
      next_cycle();
    end
    @(negedge clk);
    chk("to_release_wait1", m1_waitrequest, 0);
    next_cycle();
    idle_all();
`else
    // without the lock feature the lock input changes nothing
    apply_reset();
    drive0(1, 0, 'h010, 'hF, 0, 1);
    drive1(1, 0, 'h040, 'hF, 0, 0);
    @(negedge clk);
    chk("nolk_c0_wait1", m1_waitrequest, 1);
    next_cycle();
    drive0(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("nolk_c1_wait1", m1_waitrequest, 0);
    next_cycle();
    idle_all();
`endif

    // reset during an outstanding read drops the return
    apply_reset();
    drive1(1, 0, 'h030, 'hF, 0, 0);
    @(negedge clk);
    chk("rr_wait1", m1_waitrequest, 0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    idle_all();
    @(negedge clk);
    chk("rr_rdv1_in_rst", m1_readdatavalid, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rr_rdv1_after", m1_readdatavalid, 0);
      next_cycle();
    end
    drive0(1, 0, 'h031, 'hF, 0, 0);
    drive1(1, 0, 'h032, 'hF, 0, 0);
    @(negedge clk);
    chk("rr_tie_wait0", m0_waitrequest, 0);
    chk("rr_tie_wait1", m1_waitrequest, 1);
    next_cycle();
    idle_all();

    // vector table
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive0(vecs[i].rd0, vecs[i].wr0, 'h100 + i, 'hF, 32'h1111_0000 + i, 0);
      drive1(vecs[i].rd1, vecs[i].wr1, 'h200 + i, 'hF, 32'h2222_0000 + i, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_wait0", i), m0_waitrequest, vecs[i].w0);
      chk($sformatf("vec%0d_wait1", i), m1_waitrequest, vecs[i].w1);
      chk($sformatf("vec%0d_cs", i), mem_chipselect, vecs[i].cs);
      chk($sformatf("vec%0d_memwr", i), mem_write, vecs[i].wr);
      chk($sformatf("vec%0d_rdv0", i), m0_readdatavalid, vecs[i].rdv0);
      chk($sformatf("vec%0d_rdv1", i), m1_readdatavalid, vecs[i].rdv1);
      chk($sformatf("vec%0d_addr", i), mem_address, (vecs[i].win == 2) ? ('h200 + i) : ('h100 + i));
      next_cycle();
    end
    idle_all();

    // randomized traffic against the reference model
    apply_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = ram[i];
    mlast = 1;
    pend_who = -1;
    pend_data = '0;
    for (int n = 0; n < 600; n++) begin
      int op0, op1, win, a0, a1, b0, b1;
      bit r0, r1, wr_win, rd_win;
      logic [31:0] d0, d1;
      op0 = $urandom_range(0, 3); op1 = $urandom_range(0, 3);
      a0 = $urandom_range(0, 15); a1 = $urandom_range(0, 15);
      b0 = $urandom_range(0, 15); b1 = $urandom_range(0, 15);
      d0 = $urandom; d1 = $urandom;
      drive0(op0[0], op0[1], a0, b0, d0, 0);
      drive1(op1[0], op1[1], a1, b1, d1, 0);
      r0 = (op0 != 0);
      r1 = (op1 != 0);
      if (r0 && r1) win = (mlast == 0) ? 2 : 1;
      else if (r0)  win = 1;
      else if (r1)  win = 2;
      else          win = 0;
      wr_win = (win == 1) ? op0[1] : (win == 2) ? op1[1] : 1'b0;
      rd_win = (win != 0) && !wr_win;
      @(negedge clk);
      chk("rnd_wait0", m0_waitrequest, r0 && win != 1);
      chk("rnd_wait1", m1_waitrequest, r1 && win != 2);
      chk("rnd_cs", mem_chipselect, win != 0);
      chk("rnd_memwr", mem_write, wr_win);
      chk("rnd_rdv0", m0_readdatavalid, pend_who == 0);
      chk("rnd_rdv1", m1_readdatavalid, pend_who == 1);
      if (pend_who == 0) chk("rnd_data0", m0_readdata, pend_data);
      if (pend_who == 1) chk("rnd_data1", m1_readdata, pend_data);
      pend_who = -1;
      if (win != 0) begin
        int wa, wb;
        logic [31:0] wd;
        mlast = win - 1;
        wa = (win == 1) ? a0 : a1;
        wb = (win == 1) ? b0 : b1;
        wd = (win == 1) ? d0 : d1;
        if (wr_win) begin
          for (int b = 0; b < BE_W; b++)
            if (wb[b]) ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
        end else if (rd_win) begin
          pend_who = win - 1;
          pend_data = ref_mem[wa];
        end
      end
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    chk("rnd_tail_rdv0", m0_readdatavalid, pend_who == 0);
    chk("rnd_tail_rdv1", m1_readdatavalid, pend_who == 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-master Avalon-MM arbiter that shares the single-port 1024x32 on-chip RAM (1-cycle read latency, byteenable writes) between the Nios II data master and a second requester (DMA/video). Sits between the interconnect masters and the RAM slave port. Sequences one access per cycle with round-robin fairness, returns read data to the correct master, and optionally supports locked read-modify-write sequences.

## Interface
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data width; BE_W = DATA_W/8
- LOCK_TIMEOUT, 16, idle cycles after which a held lock is force-released (lock feature only)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  BE_W  write byte lanes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_lock / m1_lock  in  1  hold grant after this transfer (ignored unless lock feature built)
- m0_waitrequest / m1_waitrequest  out  1  request stalled this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  BE_W  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_readdata  in  DATA_W  from RAM, valid 1 cycle after address

## Operation
- Request mX = mX_read | mX_write. Read and write together: write wins, no readdatavalid.
- Winner chosen combinationally each cycle; winner's signals muxed to mem_*, mem_chipselect=1, mem_write = winner's write. No request: mem_chipselect=0, mem_write=0, mem_* data/address from m0.
- mX_waitrequest = request_X & ~grant_X; 0 when not requesting.
- Round robin: register `last` (reset 1). Both requesting: grant master != last. One requesting: it wins. `last` updates to winner on every granted cycle.
- Read return: registered rd_owner (2 bits, one-hot, reset 0) set on granted read; next cycle mX_readdatavalid = rd_owner[X], mX_readdata = mem_readdata (both readdata outputs carry mem_readdata; only valid flag qualifies).
- Lock FSM (feature-gated) states IDLE, OWN0, OWN1:
  - IDLE -> OWNx on granted transfer by mX with mX_lock=1.
  - OWNx: only mX may be granted; other master waits regardless of `last`.
  - OWNx -> IDLE on granted mX transfer with mX_lock=0, or when idle counter reaches LOCK_TIMEOUT.
  - Idle counter: clears on any mX request in OWNx, increments otherwise, saturates; clears in IDLE.

## Timing
- Reset (reset_n low, async): last=1, rd_owner=0, FSM=IDLE, counter=0; readdatavalid=0; waitrequest follows combinational rule (0 with no requests).
- Write: granted cycle N, RAM commits at end of N; 0 wait states when uncontended.
- Read: granted cycle N, readdatavalid + data in N+1. Back-to-back reads one per cycle, any master mix.
- Write then read same address on consecutive cycles returns new data.
- Contention: loser stalls exactly 1 cycle per competing grant; with both continuously requesting, grants alternate every cycle.
- Reset asserted mid-read: pending readdatavalid is dropped (never asserted).
- Timeout release: counter reaching LOCK_TIMEOUT at edge E returns IDLE at E; other master may be granted the cycle after E.

## Configuration
- ONCHIP_ARB_LOCK_EN defined: lock inputs honoured, FSM and idle counter built.
- Not defined: lock ports present but ignored, FSM/counter removed, pure round robin.

## Test plan
- Reset, m0 write 0xDEADBEEF to addr 0x005 be=0xF, then m0 read 0x005 -> waitrequest 0 both cycles, m0_readdatavalid high one cycle after read with 0xDEADBEEF, m1_readdatavalid stays 0.
- m0 and m1 both read continuously from reset for 6 cycles -> grants m0,m1,m0,m1,m0,m1; each readdatavalid pulses every other cycle, data matches issuing address.
- m1 write 0x12345678 be=0x3 over 0xFFFFFFFF at 0x3FF, then m0 read 0x3FF -> 0xFFFF5678.
- (LOCK_EN) m0 read 0x010 lock=1, m1 requesting throughout; m0 write lock=0 two cycles later -> m1 waitrequest high until cycle after m0's unlocked write, then granted.
- (LOCK_EN) m0 locked read then idle 16 cycles with m1 requesting -> m1 granted in cycle 17 after release; without macro m1 granted next cycle.
- reset_n pulsed low the cycle after granted m1 read -> m1_readdatavalid never asserts; post-reset first tie grants m0.
